// File: rtl/poly_deconv3_pkg.sv
// poly_deconv3_pkg
// Shared definitions for the polynomial deconvolution unit and its
// floating-point helpers: FSM state encoding, single-precision field
// positions and constants, and small classification helpers.
// Optional build macro used by the design: POLY_DECONV3_RESIDUE_EN.
package poly_deconv3_pkg;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_ERR,
        ST_M0,
        ST_M1,
        ST_S1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_S2,
        ST_S3,
        ST_M5,
        ST_RM0,
        ST_RM1,
        ST_RS0,
        ST_RS1,
        ST_RM2,
        ST_RS2,
        ST_DONE
    } state_e;

    localparam int          FP_SIGN_BIT = 31;
    localparam int          FP_EXP_MSB  = 30;
    localparam int          FP_EXP_LSB  = 23;
    localparam logic [31:0] FP_ONE      = 32'h3F800000;
    localparam logic [31:0] FP_QNAN     = 32'h7FC00000;

    // Subtraction is done by flipping the sign of the subtrahend.
    function automatic logic [31:0] fp_neg(input logic [31:0] v);
        return {~v[FP_SIGN_BIT], v[FP_SIGN_BIT-1:0]};
    endfunction

    // Denormals are treated as zero by the arithmetic units.
    function automatic logic fp_is_zero(input logic [31:0] v);
        return v[FP_EXP_MSB:FP_EXP_LSB] == 8'h00;
    endfunction

    function automatic logic fp_is_inf(input logic [31:0] v);
        return (v[FP_EXP_MSB:FP_EXP_LSB] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction

    function automatic logic fp_is_nan(input logic [31:0] v);
        return (v[FP_EXP_MSB:FP_EXP_LSB] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/poly_deconv3_fpu.sv
// Shared single-precision arithmetic units used by poly_deconv3.
// fpmul: z_o = a_i * b_i, valid LAT cycles after the operands are presented.
// fpadd: out_o = a_i + b_i, valid LAT cycles after the operands are presented.
// Ports: clk_i clock; a_i/b_i 32-bit operands; z_o/out_o 32-bit result.
// Round-to-nearest-even, denormal inputs/outputs flushed to zero,
// overflow to infinity, invalid operations give a quiet NaN.
module fpmul #(
    parameter int LAT = 1
) (
    input  logic        clk_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] z_o
);
    import poly_deconv3_pkg::*;

    function automatic logic [31:0] mul_f(input logic [31:0] a, input logic [31:0] b);
        logic        sz;
        logic [47:0] p;
        logic [22:0] m;
        logic        g;
        logic        st;
        logic [23:0] mr;
        int          e;
        sz = a[31] ^ b[31];
        if (fp_is_nan(a) || fp_is_nan(b) ||
            (fp_is_inf(a) && fp_is_zero(b)) || (fp_is_zero(a) && fp_is_inf(b)))
            return FP_QNAN;
        if (fp_is_inf(a) || fp_is_inf(b))
            return {sz, 8'hFF, 23'd0};
        if (fp_is_zero(a) || fp_is_zero(b))
            return {sz, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m  = p[46:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 1;
        end else begin
            m  = p[45:23];
            g  = p[22];
            st = |p[21:0];
        end
        mr = {1'b0, m} + {23'd0, g & (st | m[0])};
        if (mr[23]) begin
            e = e + 1;
            m = 23'd0;
        end else begin
            m = mr[22:0];
        end
        if (e >= 255)
            return {sz, 8'hFF, 23'd0};
        if (e <= 0)
            return {sz, 31'd0};
        return {sz, e[7:0], m};
    endfunction

    logic [31:0] pipe_q [LAT];

    always_ff @(posedge clk_i) begin
        pipe_q[0] <= mul_f(a_i, b_i);
        for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end

    assign z_o = pipe_q[LAT-1];

endmodule

module fpadd #(
    parameter int LAT = 1
) (
    input  logic        clk_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] out_o
);
    import poly_deconv3_pkg::*;

    function automatic logic [31:0] add_f(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  d;
        logic [26:0] mx;
        logic [26:0] my;
        logic [27:0] s;
        logic [22:0] m;
        logic        g;
        logic        st;
        logic [23:0] mr;
        int          e;
        int          lz;
        if (fp_is_nan(a) || fp_is_nan(b) ||
            (fp_is_inf(a) && fp_is_inf(b) && (a[31] != b[31])))
            return FP_QNAN;
        if (fp_is_inf(a)) return a;
        if (fp_is_inf(b)) return b;
        // Two zeros: negative only when both are negative.
        if (fp_is_zero(a) && fp_is_zero(b)) return {a[31] & b[31], 31'd0};
        if (fp_is_zero(a)) return b;
        if (fp_is_zero(b)) return a;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        // Mantissas carry guard, round and sticky bits below the LSB.
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        if (d >= 8'd27) begin
            my = 27'd1;
        end else begin
            st = |(my & ((27'd1 << d) - 27'd1));
            my = (my >> d) | {26'd0, st};
        end
        if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
        else                s = {1'b0, mx} - {1'b0, my};
        // Exact cancellation yields +0.
        if (s == 28'd0) return 32'd0;
        e = int'(x[30:23]);
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 1;
        end else begin
            lz = 0;
            for (int i = 0; i < 27; i++) if (s[i]) lz = 26 - i;
            s = s << lz;
            e = e - lz;
        end
        m  = s[25:3];
        g  = s[2];
        st = s[1] | s[0];
        mr = {1'b0, m} + {23'd0, g & (st | m[0])};
        if (mr[23]) begin
            e = e + 1;
            m = 23'd0;
        end else begin
            m = mr[22:0];
        end
        if (e >= 255)
            return {x[31], 8'hFF, 23'd0};
        if (e <= 0)
            return {x[31], 31'd0};
        return {x[31], e[7:0], m};
    endfunction

    logic [31:0] pipe_q [LAT];

    always_ff @(posedge clk_i) begin
        pipe_q[0] <= add_f(a_i, b_i);
        for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end

    assign out_o = pipe_q[LAT-1];

endmodule

// File: rtl/poly_deconv3.sv
// poly_deconv3
// Recovers the 3-term factor A from a 5-term convolution result Y and the
// known factor B by forward substitution, using one shared fpmul and one
// shared fpadd sequenced by an FSM (one operation per state).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         request, accepted only when idle
//   Y[159:0]      {Y0..Y4}, Y0 in the top word
//   B[95:0]       {B0,B1,B2}, B0 in the top word
//   B0_inv[31:0]  caller-supplied 1/B0
//   busy          high from acceptance until done
//   done          one-cycle pulse, A/err (and R) valid and held until next start
//   err           B0 was zero or denormal
//   A[95:0]       {A0,A1,A2}
//   R[63:0]       {R3,R4} residue, only when POLY_DECONV3_RESIDUE_EN is defined
module poly_deconv3
    import poly_deconv3_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int ADD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [159:0] Y,
    input  logic [95:0]  B,
    input  logic [31:0]  B0_inv,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [95:0]  A
`ifdef POLY_DECONV3_RESIDUE_EN
    ,
    output logic [63:0]  R
`endif
);

    localparam logic [7:0] MUL_LAST = 8'(MUL_LAT);
    localparam logic [7:0] ADD_LAST = 8'(ADD_LAT);

    state_e       state_q, state_d, op_next;
    logic [7:0]   cnt_q, cnt_d, op_last;
    logic [159:0] y_q;
    logic [63:0]  b_q;
    logic [31:0]  inv_q, a0_q, a1_q, a2_q, t_q, t2_q, u_q;
    logic         err_q;
    logic [31:0]  mul_a, mul_b, mul_z, add_a, add_b, add_z;
    logic         op_act, op_add, op_fin;
    logic         unused_bits;

    wire [31:0] y0 = y_q[159:128];
    wire [31:0] y1 = y_q[127:96];
    wire [31:0] y2 = y_q[95:64];
    wire [31:0] b1 = b_q[63:32];
    wire [31:0] b2 = b_q[31:0];

`ifdef POLY_DECONV3_RESIDUE_EN
    logic [31:0] r3_q, r4_q;
    wire  [31:0] y3 = y_q[63:32];
    wire  [31:0] y4 = y_q[31:0];
    assign R           = {r3_q, r4_q};
    assign unused_bits = ^{B[95], B[86:64]};
`else
    assign unused_bits = ^{y_q[63:0], B[95], B[86:64]};
`endif

    fpmul #(.LAT(MUL_LAT)) u_mul (.clk_i(clk), .a_i(mul_a), .b_i(mul_b), .z_o(mul_z));
    fpadd #(.LAT(ADD_LAT)) u_add (.clk_i(clk), .a_i(add_a), .b_i(add_b), .out_o(add_z));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_next = ST_DONE;
        op_act  = 1'b0;
        op_add  = 1'b0;
        mul_a   = 32'd0;
        mul_b   = 32'd0;
        add_a   = 32'd0;
        add_b   = 32'd0;
        unique case (state_q)
            // B0 is classified straight off the input bus on the accepting edge;
            // it is the same value that gets latched.
            ST_IDLE: if (start) state_d = (B[64+FP_EXP_MSB:64+FP_EXP_LSB] == 8'd0) ? ST_ERR : ST_M0;
            ST_ERR:  state_d = ST_DONE;
            ST_M0:   begin op_act = 1'b1; mul_a = y0;   mul_b = inv_q; op_next = ST_M1; end
            ST_M1:   begin op_act = 1'b1; mul_a = a0_q; mul_b = b1;    op_next = ST_S1; end
            ST_S1:   begin op_act = 1'b1; op_add = 1'b1; add_a = y1; add_b = fp_neg(t_q);  op_next = ST_M2; end
            ST_M2:   begin op_act = 1'b1; mul_a = u_q;  mul_b = inv_q; op_next = ST_M3; end
            ST_M3:   begin op_act = 1'b1; mul_a = a0_q; mul_b = b2;    op_next = ST_M4; end
            ST_M4:   begin op_act = 1'b1; mul_a = a1_q; mul_b = b1;    op_next = ST_S2; end
            ST_S2:   begin op_act = 1'b1; op_add = 1'b1; add_a = y2;  add_b = fp_neg(t_q);  op_next = ST_S3; end
            ST_S3:   begin op_act = 1'b1; op_add = 1'b1; add_a = u_q; add_b = fp_neg(t2_q); op_next = ST_M5; end
`ifdef POLY_DECONV3_RESIDUE_EN
            ST_M5:   begin op_act = 1'b1; mul_a = u_q;  mul_b = inv_q; op_next = ST_RM0; end
            ST_RM0:  begin op_act = 1'b1; mul_a = a1_q; mul_b = b2;    op_next = ST_RM1; end
            ST_RM1:  begin op_act = 1'b1; mul_a = a2_q; mul_b = b1;    op_next = ST_RS0; end
            ST_RS0:  begin op_act = 1'b1; op_add = 1'b1; add_a = t_q; add_b = t2_q;        op_next = ST_RS1; end
            ST_RS1:  begin op_act = 1'b1; op_add = 1'b1; add_a = y3;  add_b = fp_neg(u_q); op_next = ST_RM2; end
            ST_RM2:  begin op_act = 1'b1; mul_a = a2_q; mul_b = b2;    op_next = ST_RS2; end
            ST_RS2:  begin op_act = 1'b1; op_add = 1'b1; add_a = y4;  add_b = fp_neg(t_q); op_next = ST_DONE; end
`else
            ST_M5:   begin op_act = 1'b1; mul_a = u_q;  mul_b = inv_q; op_next = ST_DONE; end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Operands stay on the unit for the whole op; the result is taken on
        // the last wait cycle, when the counter reaches the unit latency.
        op_last = op_add ? ADD_LAST : MUL_LAST;
        op_fin  = op_act && (cnt_q == op_last);
        if (op_act) begin
            if (op_fin) begin
                cnt_d   = 8'd0;
                state_d = op_next;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            y_q     <= '0;
            b_q     <= '0;
            inv_q   <= '0;
            a0_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
            t_q     <= '0;
            t2_q    <= '0;
            u_q     <= '0;
            err_q   <= 1'b0;
`ifdef POLY_DECONV3_RESIDUE_EN
            r3_q    <= '0;
            r4_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && start) begin
                y_q   <= Y;
                b_q   <= B[63:0];
                inv_q <= B0_inv;
                err_q <= 1'b0;
                a0_q  <= '0;
                a1_q  <= '0;
                a2_q  <= '0;
`ifdef POLY_DECONV3_RESIDUE_EN
                r3_q  <= '0;
                r4_q  <= '0;
`endif
            end
            if (state_q == ST_ERR) err_q <= 1'b1;
            if (op_fin) begin
                case (state_q)
                    ST_M0:               a0_q <= mul_z;
                    ST_M2:               a1_q <= mul_z;
                    ST_M5:               a2_q <= mul_z;
                    ST_M1, ST_M3:        t_q  <= mul_z;
                    ST_M4:               t2_q <= mul_z;
                    ST_S1, ST_S2, ST_S3: u_q  <= add_z;
`ifdef POLY_DECONV3_RESIDUE_EN
                    ST_RM0, ST_RM2:      t_q  <= mul_z;
                    ST_RM1:              t2_q <= mul_z;
                    ST_RS0:              u_q  <= add_z;
                    ST_RS1:              r3_q <= add_z;
                    ST_RS2:              r4_q <= add_z;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done = (state_q == ST_DONE);
    assign err  = err_q;
    assign A    = {a0_q, a1_q, a2_q};

endmodule

// File: tb/tb_poly_deconv3.sv
// tb_poly_deconv3
// Directed-vector bench for poly_deconv3 at MUL_LAT=ADD_LAT=1.
// Expected quotients and residues are hand-computed small-integer results.
`timescale 1ns/1ps
module tb_poly_deconv3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [159:0] Y = '0;
    logic [95:0]  B = '0;
    logic [31:0]  B0_inv = '0;
    logic         busy, done, err;
    logic [95:0]  A;
`ifdef POLY_DECONV3_RESIDUE_EN
    logic [63:0]  R;
    localparam int LAT_EXP = 31;
`else
    localparam int LAT_EXP = 19;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [159:0] V1_Y   = {32'h3F800000, 32'h40400000, 32'h40C00000, 32'h40A00000, 32'h40400000};
    localparam logic [95:0]  V1_B   = {32'h3F800000, 32'h3F800000, 32'h3F800000};
    localparam logic [31:0]  V1_INV = 32'h3F800000;
    localparam logic [95:0]  A1_EXP = {32'h3F800000, 32'h40000000, 32'h40400000};
    localparam logic [159:0] V2_Y   = {32'h40000000, 32'h40800000, 32'h40C00000, 64'd0};
    localparam logic [95:0]  V2_B   = {32'h40000000, 64'd0};
    localparam logic [31:0]  V2_INV = 32'h3F000000;
    // A = {2,3,4} with B = {1,1,1}; Y3/Y4 chosen so the residue is zero.
    localparam logic [159:0] V3_Y   = {32'h40000000, 32'h40A00000, 32'h41100000, 32'h40E00000, 32'h40800000};
    localparam logic [95:0]  A3_EXP = {32'h40000000, 32'h40400000, 32'h40800000};

    always #5 clk = ~clk;

    poly_deconv3 #(.MUL_LAT(1), .ADD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .Y(Y), .B(B), .B0_inv(B0_inv),
        .busy(busy), .done(done), .err(err), .A(A)
`ifdef POLY_DECONV3_RESIDUE_EN
        , .R(R)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; returns in cycle 1 of the run.
    task automatic issue(input logic [159:0] y, input logic [95:0] b, input logic [31:0] inv);
        Y = y; B = b; B0_inv = inv; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Returns the cycle index at which done is seen, 0 if the budget expires.
    task automatic wait_done(input int maxc, output int cyc);
        cyc = 0;
        for (int c = 1; c <= maxc; c++) begin
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        step(); step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (err  !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (A !== 96'd0) begin n_fail++; $display("FAIL reset_A: got %h want 0", A); end
`ifdef POLY_DECONV3_RESIDUE_EN
        n_checks++; if (R !== 64'd0) begin n_fail++; $display("FAIL reset_R: got %h want 0", R); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int cyc;
        issue(V1_Y, V1_B, V1_INV);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_done(60, cyc);
        n_checks++; if (cyc != LAT_EXP) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", cyc, LAT_EXP); end
        n_checks++; if (A !== A1_EXP) begin n_fail++; $display("FAIL basic_A: got %h want %h", A, A1_EXP); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b want 0", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
`ifdef POLY_DECONV3_RESIDUE_EN
        n_checks++; if (R !== 64'd0) begin n_fail++; $display("FAIL basic_R: got %h want 0", R); end
`endif
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        n_checks++; if (A !== A1_EXP) begin n_fail++; $display("FAIL basic_A_hold: got %h want %h", A, A1_EXP); end
    endtask

    task automatic test_scale();
        int cyc;
        issue(V2_Y, V2_B, V2_INV);
        wait_done(60, cyc);
        n_checks++; if (cyc != LAT_EXP) begin n_fail++; $display("FAIL scale_latency: got %0d want %0d", cyc, LAT_EXP); end
        n_checks++; if (A !== A1_EXP) begin n_fail++; $display("FAIL scale_A: got %h want %h", A, A1_EXP); end
`ifdef POLY_DECONV3_RESIDUE_EN
        n_checks++; if (R !== 64'd0) begin n_fail++; $display("FAIL scale_R: got %h want 0", R); end
`endif
        step();
    endtask

    task automatic test_err();
        int cyc;
        issue(V1_Y, {32'h00000000, 32'h3F800000, 32'h3F800000}, V1_INV);
        wait_done(10, cyc);
        n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL err_latency: got %0d want 2", cyc); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", err); end
        n_checks++; if (A !== 96'd0) begin n_fail++; $display("FAIL err_A: got %h want 0", A); end
`ifdef POLY_DECONV3_RESIDUE_EN
        n_checks++; if (R !== 64'd0) begin n_fail++; $display("FAIL err_R: got %h want 0", R); end
`endif
        step();
        n_checks++; if (done !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL err_hold: got done=%b err=%b want done=0 err=1", done, err); end
        issue(V1_Y, V1_B, V1_INV);
        n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL err_clear: got err=%b busy=%b want err=0 busy=1", err, busy); end
        wait_done(60, cyc);
        n_checks++; if (A !== A1_EXP || err !== 1'b0) begin n_fail++; $display("FAIL err_recover: got A=%h err=%b want A=%h err=0", A, err, A1_EXP); end
        step();
    endtask

    task automatic test_residue();
        int cyc;
        logic [159:0] y;
        y = V1_Y;
        y[31:0] = 32'h40800000;
        issue(y, V1_B, V1_INV);
        wait_done(60, cyc);
        n_checks++; if (A !== A1_EXP) begin n_fail++; $display("FAIL residue_A: got %h want %h", A, A1_EXP); end
`ifdef POLY_DECONV3_RESIDUE_EN
        n_checks++; if (R !== {32'h00000000, 32'h3F800000}) begin n_fail++; $display("FAIL residue_R: got %h want 000000003f800000", R); end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int ndone;
        int first;
        logic [95:0] a_at_done;
        ndone = 0; first = 0; a_at_done = '0;
        issue(V1_Y, V1_B, V1_INV);
        for (int c = 1; c <= LAT_EXP; c++) begin
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) begin first = c; a_at_done = A; end
            end
            if (c == 5 || c == 19) begin
                Y = V3_Y; B = V1_B; B0_inv = V1_INV; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        n_checks++; if (ndone != 1 || first != LAT_EXP) begin n_fail++; $display("FAIL b2b_single_done: got count=%0d at %0d want 1 at %0d", ndone, first, LAT_EXP); end
        n_checks++; if (a_at_done !== A1_EXP) begin n_fail++; $display("FAIL b2b_first_A: got %h want %h", a_at_done, A1_EXP); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got busy=%b done=%b want 0 0", busy, done); end
        issue(V3_Y, V1_B, V1_INV);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        wait_done(60, cyc);
        n_checks++; if (cyc != LAT_EXP || A !== A3_EXP) begin n_fail++; $display("FAIL b2b_second: got cyc=%0d A=%h want cyc=%0d A=%h", cyc, A, LAT_EXP, A3_EXP); end
`ifdef POLY_DECONV3_RESIDUE_EN
        n_checks++; if (R !== 64'd0) begin n_fail++; $display("FAIL b2b_R: got %h want 0", R); end
`endif
        step();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int ndone;
        issue(V1_Y, V1_B, V1_INV);
        for (int c = 1; c < 7; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%b done=%b want 0 0", busy, done); end
        n_checks++; if (A !== 96'd0 || err !== 1'b0) begin n_fail++; $display("FAIL midrst_clear: got A=%h err=%b want 0 0", A, err); end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", ndone); end
        issue(V3_Y, V1_B, V1_INV);
        wait_done(60, cyc);
        n_checks++; if (cyc != LAT_EXP || A !== A3_EXP) begin n_fail++; $display("FAIL midrst_fresh: got cyc=%0d A=%h want cyc=%0d A=%h", cyc, A, LAT_EXP, A3_EXP); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scale();
        test_err();
        test_residue();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
